// File: rtl/sar_pkg.sv
// Shared definitions between the SAR conversion stage and its result buffer.
package sar_pkg;

    // Width of one SAR conversion code.
    localparam int DATA_W = 4;

    typedef logic [DATA_W-1:0] sar_code_t;

    // Width of a sum of 2^log2_avg codes: it can never exceed this width.
    function automatic int avg_w(input int log2_avg);
        return DATA_W + log2_avg;
    endfunction

endpackage

// File: rtl/sar_avg_buffer_if.sv
// Sample-in / result-out handshake bundle of the SAR averaging buffer.
interface sar_avg_buffer_if
    import sar_pkg::*;
#(
    parameter int OUT_W = avg_w(2)
);

    logic             in_valid;   // one-cycle pulse per completed conversion
    sar_code_t        in_code;    // conversion code, meaningful while in_valid=1
    logic             out_valid;  // a block sum is waiting at the head
    logic [OUT_W-1:0] out_data;   // head block sum
    logic             out_ready;  // consumer takes the head this cycle

    // Buffer side.
    modport slave (
        input  in_valid, in_code, out_ready,
        output out_valid, out_data
    );

    // Producer / consumer side.
    modport master (
        output in_valid, in_code, out_ready,
        input  out_valid, out_data
    );

endinterface

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is always on head_data.
module sar_result_fifo #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = CW'(wr_ptr_q - rd_ptr_q);

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so push while full is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer next-state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: storage is reset so the head reads 0 after reset; affordable at this depth.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sar_avg_buffer.sv
// Oversampling averager for SAR codes: sums blocks of 2^LOG2_AVG samples and
// queues each block sum in a small FWFT FIFO drained by a valid/ready consumer.
module sar_avg_buffer
    import sar_pkg::*;
#(
    parameter  int LOG2_AVG   = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int OUT_W      = avg_w(LOG2_AVG),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    sar_avg_buffer_if.slave     bus,
    output logic [CNT_W-1:0]    fifo_count,
    output logic [LOG2_AVG-1:0] sample_idx,
    output logic                overflow,
    input  logic                clear_ovf
);

    localparam logic [LOG2_AVG-1:0] LAST_IDX = '1;

    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [LOG2_AVG-1:0] idx_q, idx_d;
    logic                ovf_q, ovf_d;

    logic             accept;
    logic             block_done;
    logic [OUT_W-1:0] sum;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             drop;

    assign accept     = enable && bus.in_valid;
    assign block_done = accept && (idx_q == LAST_IDX);
    assign sum        = acc_q + OUT_W'(bus.in_code);

    assign pop  = bus.out_valid && bus.out_ready;
    assign drop = block_done && fifo_full && !pop;

    assign bus.out_valid = !fifo_empty;
    assign sample_idx    = idx_q;
    assign overflow      = ovf_q;

    sar_result_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (block_done),
        .push_data (sum),
        .pop       (pop),
        .head_data (bus.out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Accumulator / sample index / overflow next-state; enable low aborts the block.
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        ovf_d = ovf_q;
        if (!enable) begin
            acc_d = '0;
            idx_d = '0;
        end else if (bus.in_valid) begin
            acc_d = block_done ? '0 : sum;
            idx_d = idx_q + 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (clear_ovf) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    // Accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
        end
    end

endmodule
